// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Shares the single-port 128 x 32-bit data memory between the pipeline MEM
// stage (CPU) and a DMA/debug loader port. One access is granted per cycle.
// The CPU has priority. A starvation limit bounds how long a pending DMA
// request can wait. The pipeline is stalled on any cycle where the DMA port
// wins while the CPU also wants the memory.
//
// Parameters
//   MAX_CPU_RUN  consecutive CPU grants allowed while DMA is pending (1..15)
//   CNT_W        width of the saturating diagnostic stall counter
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_memread/memwrite       MEM-stage read / write request
//   cpu_addr, cpu_wdata        byte address (word = cpu_addr[8:2]), store data
//   cpu_rdata                  load data to MEM/WB (0 when CPU not granted)
//   cpu_stall                  hold IF..MEM this cycle
//   dma_valid/we/addr/wdata    DMA request (held stable until dma_ready)
//   dma_ready                  DMA request accepted this cycle
//   dma_rvalid, dma_rdata      registered DMA read response
//   dm_addr/rd/wr/wdata        data memory control and write data
//   dm_rdata                   data memory read data (combinational)
//   dbg_stall_cnt              saturating count of stalled cycles
// -----------------------------------------------------------------------------
module dm_arbiter #(
   parameter int MAX_CPU_RUN = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_memread,
   input  logic             cpu_memwrite,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   input  logic             dma_valid,
   input  logic             dma_we,
   input  logic [6:0]       dma_addr,
   input  logic [31:0]      dma_wdata,
   output logic             dma_ready,
   output logic             dma_rvalid,
   output logic [31:0]      dma_rdata,
   output logic [6:0]       dm_addr,
   output logic             dm_rd,
   output logic             dm_wr,
   output logic [31:0]      dm_wdata,
   input  logic [31:0]      dm_rdata,
   output logic [CNT_W-1:0] dbg_stall_cnt
);

   localparam logic [3:0]       RUN_LIMIT = 4'(MAX_CPU_RUN);
   localparam logic [3:0]       RUN_MAX   = 4'hF;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   // Saturating increment of the CPU run counter.
   function automatic logic [3:0] sat_inc_run(input logic [3:0] value);
      if (value == RUN_MAX) begin
         return RUN_MAX;
      end
      return value + 4'd1;
   endfunction

   // Saturating increment of the diagnostic stall counter.
   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] value);
      if (value == CNT_MAX) begin
         return CNT_MAX;
      end
      return value + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic       cpu_req;
   logic       dma_req;
   logic       grant_cpu;
   logic       grant_dma;
   logic [3:0] run;

   assign cpu_req = cpu_memread | cpu_memwrite;
   assign dma_req = dma_valid;

   // ---- grant selection (combinational) ----
   // Reset forces no grant, which idles every combinational output and
   // guarantees no memory write while reset is high.
   always_comb begin
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      if (!reset) begin
         if (cpu_req && dma_req) begin
            if (run < RUN_LIMIT) begin
               grant_cpu = 1'b1;
            end else begin
               grant_dma = 1'b1;
            end
         end else if (cpu_req) begin
            grant_cpu = 1'b1;
         end else if (dma_req) begin
            grant_dma = 1'b1;
         end
      end
   end

   // Memory-side and requester-side steering. An illegal CPU access with
   // both memread and memwrite set passes both enables through untouched.
   always_comb begin
      dm_addr   = 7'd0;
      dm_rd     = 1'b0;
      dm_wr     = 1'b0;
      dm_wdata  = 32'd0;
      cpu_rdata = 32'd0;
      cpu_stall = 1'b0;
      dma_ready = 1'b0;
      if (grant_cpu) begin
         dm_addr   = cpu_addr[8:2];
         dm_rd     = cpu_memread;
         dm_wr     = cpu_memwrite;
         dm_wdata  = cpu_wdata;
         cpu_rdata = dm_rdata;
      end else if (grant_dma) begin
         dm_addr   = dma_addr;
         dm_rd     = ~dma_we;
         dm_wr     = dma_we;
         dm_wdata  = dma_wdata;
         dma_ready = 1'b1;
         cpu_stall = cpu_req;
      end
   end

   // ---- registered state (posedge clk) ----
   // run counts CPU grants taken while DMA waits. It clears whenever DMA is
   // served or stops asking, so a forced DMA slot costs the CPU at most one
   // cycle before the CPU wins again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run <= 4'd0;
      end else if (grant_dma || !dma_valid) begin
         run <= 4'd0;
      end else if (grant_cpu) begin
         run <= sat_inc_run(run);
      end
   end

   // DMA read response: rvalid pulses for one cycle per accepted read,
   // rdata holds until the next accepted read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dma_rvalid <= 1'b0;
         dma_rdata  <= 32'd0;
      end else begin
         dma_rvalid <= grant_dma & ~dma_we;
         if (grant_dma && !dma_we) begin
            dma_rdata <= dm_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dbg_stall_cnt <= '0;
      end else if (cpu_stall) begin
         dbg_stall_cnt <= sat_inc_cnt(dbg_stall_cnt);
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_memread, cpu_memwrite;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        dma_valid, dma_we;
   logic [6:0]  dma_addr;
   logic [31:0] dma_wdata;

   logic [31:0] cpu_rdata, dma_rdata, dm_wdata, dm_rdata;
   logic        cpu_stall, dma_ready, dma_rvalid, dm_rd, dm_wr;
   logic [6:0]  dm_addr;
   logic [15:0] dbg_stall_cnt;

   logic [31:0] cpu_rdata4, dma_rdata4, dm_wdata4, dm_rdata4;
   logic        cpu_stall4, dma_ready4, dma_rvalid4, dm_rd4, dm_wr4;
   logic [6:0]  dm_addr4;
   logic [3:0]  dbg_stall_cnt4;

   logic [31:0] mem [0:127] = '{default: 32'h0};

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   // Behavioural single-port data memory driven by the main instance.
   assign dm_rdata  = mem[dm_addr];
   assign dm_rdata4 = mem[dm_addr4];
   always @(posedge clk) begin
      if (dm_wr) mem[dm_addr] <= dm_wdata;
   end

   dm_arbiter #(.MAX_CPU_RUN(4), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_ready(dma_ready),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .dbg_stall_cnt(dbg_stall_cnt)
   );

   // Narrow-counter instance sharing the same stimulus; only its counter is
   // observed, its memory writes are not applied.
   dm_arbiter #(.MAX_CPU_RUN(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata4), .cpu_stall(cpu_stall4),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_ready(dma_ready4),
      .dma_rvalid(dma_rvalid4), .dma_rdata(dma_rdata4),
      .dm_addr(dm_addr4), .dm_rd(dm_rd4), .dm_wr(dm_wr4),
      .dm_wdata(dm_wdata4), .dm_rdata(dm_rdata4),
      .dbg_stall_cnt(dbg_stall_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_memread  = 1'b0;
      cpu_memwrite = 1'b0;
      cpu_addr     = 32'h0;
      cpu_wdata    = 32'h0;
      dma_valid    = 1'b0;
      dma_we       = 1'b0;
      dma_addr     = 7'h0;
      dma_wdata    = 32'h0;
   endtask

   initial begin
      int accept_at;
      bit exp_dma;

      // ---- reset state with live requests ----
      idle();
      reset        = 1'b1;
      cpu_memwrite = 1'b1;
      cpu_addr     = 32'h0000_0010;
      cpu_wdata    = 32'h0BAD_0BAD;
      dma_valid    = 1'b1;
      #1;
      chk("rst_dm_wr", 32'(dm_wr), 32'd0);
      chk("rst_dm_addr", 32'(dm_addr), 32'd0);
      chk("rst_dma_ready", 32'(dma_ready), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      tick();
      tick();
      chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
      chk("rst_cnt", 32'(dbg_stall_cnt), 32'd0);
      chk("rst_no_write", mem[4], 32'h0);
      idle();
      #2;
      reset = 1'b0;

      // ---- 1: CPU store then load ----
      tick();
      cpu_memwrite = 1'b1;
      cpu_addr     = 32'h0000_0010;
      cpu_wdata    = 32'hDEAD_BEEF;
      #1;
      chk("t1_st_addr", 32'(dm_addr), 32'd4);
      chk("t1_st_wr", 32'(dm_wr), 32'd1);
      chk("t1_st_wdata", dm_wdata, 32'hDEAD_BEEF);
      chk("t1_st_stall", 32'(cpu_stall), 32'd0);
      tick();
      cpu_memwrite = 1'b0;
      cpu_memread  = 1'b1;
      #1;
      chk("t1_ld_wr", 32'(dm_wr), 32'd0);
      chk("t1_ld_rd", 32'(dm_rd), 32'd1);
      chk("t1_ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("t1_ld_stall", 32'(cpu_stall), 32'd0);
      tick();
      idle();

      // ---- 2: DMA write, read, back-to-back reads ----
      dma_valid = 1'b1;
      dma_we    = 1'b1;
      dma_addr  = 7'd7;
      dma_wdata = 32'h1234_5678;
      #1;
      chk("t2_wr_ready", 32'(dma_ready), 32'd1);
      chk("t2_wr_addr", 32'(dm_addr), 32'd7);
      chk("t2_wr_en", 32'(dm_wr), 32'd1);
      tick();
      chk("t2_wr_rvalid", 32'(dma_rvalid), 32'd0);
      dma_we = 1'b0;
      #1;
      chk("t2_rd_ready", 32'(dma_ready), 32'd1);
      chk("t2_rd_en", 32'(dm_rd), 32'd1);
      chk("t2_rd_rvalid_pre", 32'(dma_rvalid), 32'd0);
      tick();
      chk("t2_rd_rvalid", 32'(dma_rvalid), 32'd1);
      chk("t2_rd_rdata", dma_rdata, 32'h1234_5678);
      dma_valid = 1'b0;
      tick();
      chk("t2_rvalid_pulse", 32'(dma_rvalid), 32'd0);
      chk("t2_rdata_hold", dma_rdata, 32'h1234_5678);
      dma_valid = 1'b1;
      dma_addr  = 7'd4;
      tick();
      dma_addr = 7'd7;
      chk("t2_b2b_v1", 32'(dma_rvalid), 32'd1);
      chk("t2_b2b_d1", dma_rdata, 32'hDEAD_BEEF);
      tick();
      chk("t2_b2b_v2", 32'(dma_rvalid), 32'd1);
      chk("t2_b2b_d2", dma_rdata, 32'h1234_5678);
      idle();
      tick();

      // ---- 3: starvation bound, DMA forced every 5th cycle ----
      cpu_memread = 1'b1;
      cpu_addr    = 32'h0000_0010;
      dma_valid   = 1'b1;
      dma_we      = 1'b0;
      dma_addr    = 7'd7;
      for (int k = 0; k < 10; k++) begin
         exp_dma = ((k % 5) == 4);
         #1;
         chk($sformatf("t3_ready_%0d", k), 32'(dma_ready), 32'(exp_dma));
         chk($sformatf("t3_stall_%0d", k), 32'(cpu_stall), 32'(exp_dma));
         chk($sformatf("t3_rdata_%0d", k), cpu_rdata, exp_dma ? 32'h0 : 32'hDEAD_BEEF);
         tick();
      end
      chk("t3_cnt", 32'(dbg_stall_cnt), 32'd2);
      chk("t3_cnt4", 32'(dbg_stall_cnt4), 32'd2);

      // ---- 4: simultaneous requests from run=0, DMA accepted by 5th cycle ----
      dma_valid = 1'b0;
      tick();
      dma_valid = 1'b1;
      dma_we    = 1'b1;
      dma_addr  = 7'd9;
      dma_wdata = 32'hAAAA_5555;
      #1;
      chk("t4_first_ready", 32'(dma_ready), 32'd0);
      chk("t4_first_rd", 32'(dm_rd), 32'd1);
      accept_at = -1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) #1;
         if (dma_ready) begin
            accept_at = i;
            tick();
            break;
         end
         tick();
      end
      chk("t4_accept_cycle", 32'(accept_at), 32'd4);
      dma_valid = 1'b0;
      #1;
      chk("t4_mem", mem[9], 32'hAAAA_5555);
      tick();

      // ---- 5: reset in the cycle after an accepted DMA read ----
      idle();
      dma_valid = 1'b1;
      dma_addr  = 7'd9;
      tick();
      chk("t5_rvalid_pre", 32'(dma_rvalid), 32'd1);
      reset        = 1'b1;
      dma_we       = 1'b1;
      dma_wdata    = 32'h5555_AAAA;
      cpu_memwrite = 1'b1;
      cpu_addr     = 32'h0000_0010;
      cpu_wdata    = 32'h0;
      #1;
      chk("t5_rvalid", 32'(dma_rvalid), 32'd0);
      chk("t5_dm_wr", 32'(dm_wr), 32'd0);
      chk("t5_cnt", 32'(dbg_stall_cnt), 32'd0);
      chk("t5_rdata", dma_rdata, 32'd0);
      tick();
      chk("t5_mem4", mem[4], 32'hDEAD_BEEF);
      chk("t5_mem9", mem[9], 32'hAAAA_5555);
      idle();
      #2;
      reset = 1'b0;
      tick();
      cpu_memread = 1'b1;
      cpu_addr    = 32'h0000_0010;
      dma_valid   = 1'b1;
      dma_addr    = 7'd7;
      #1;
      chk("t5_cpu_first_ready", 32'(dma_ready), 32'd0);
      chk("t5_cpu_first_stall", 32'(cpu_stall), 32'd0);
      chk("t5_cpu_first_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // ---- 6: narrow stall counter saturates without wrapping ----
      for (int k = 0; k < 100; k++) begin
         tick();
         if (k == 74) begin
            chk("t6_cnt4_at15", 32'(dbg_stall_cnt4), 32'd15);
            chk("t6_cnt_at15", 32'(dbg_stall_cnt), 32'd15);
         end
      end
      chk("t6_cnt4_sat", 32'(dbg_stall_cnt4), 32'd15);
      chk("t6_cnt_20", 32'(dbg_stall_cnt), 32'd20);

      idle();
      tick();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
